// File: rtl/pifo_calendar_pkg.sv
// pifo_calendar_pkg
//   Shared types and helpers for the root PIFO calendar.
//   - entry_t        : one calendar slot {valid, rank, addr}
//   - INFO_* slices  : field positions inside the packed {rank, addr} info word
//   - rank_key_gt()  : wrap-aware rank comparison against a virtual-time base
package pifo_calendar_pkg;

  localparam int PIFO_RANK_WIDTH   = 16;
  localparam int BUFFER_ADDR_WIDTH = 12;
  localparam int PIFO_INFO_WIDTH   = PIFO_RANK_WIDTH + BUFFER_ADDR_WIDTH;

  localparam int INFO_ADDR_LSB = 0;
  localparam int INFO_ADDR_MSB = BUFFER_ADDR_WIDTH - 1;
  localparam int INFO_RANK_LSB = BUFFER_ADDR_WIDTH;
  localparam int INFO_RANK_MSB = PIFO_RANK_WIDTH + BUFFER_ADDR_WIDTH - 1;

  typedef logic [PIFO_RANK_WIDTH-1:0]   rank_t;
  typedef logic [BUFFER_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    rank_t rank;
    addr_t addr;
  } entry_t;

  // Ranks are ordered by their distance ahead of the current virtual time,
  // so a rank that has numerically wrapped past zero still sorts after one
  // just below the wrap point.
  function automatic logic rank_key_gt(rank_t a, rank_t b, rank_t base);
    rank_t key_a;
    rank_t key_b;
    key_a = a - base;
    key_b = b - base;
    return key_a > key_b;
  endfunction

endpackage

// File: rtl/pifo_calendar_slot.sv
// pifo_calendar_slot
//   One register of the calendar shift array.
//   Ports:
//     clk, rstn    : clock, asynchronous active-low reset
//     prev_slot    : neighbour toward the head (source when shifting down)
//     next_slot    : neighbour toward the tail (source when shifting up)
//     new_entry    : entry being inserted this cycle
//     insert_here  : load new_entry
//     shift_down   : load prev_slot (make room for an insert ahead of us)
//     shift_up     : load next_slot (close the gap left by a pop)
//     slot         : registered slot contents
//     slot_next    : value the slot takes at the next edge
module pifo_calendar_slot
  import pifo_calendar_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  entry_t prev_slot,
  input  entry_t next_slot,
  input  entry_t new_entry,
  input  logic   insert_here,
  input  logic   shift_down,
  input  logic   shift_up,
  output entry_t slot,
  output entry_t slot_next
);

  always_comb begin
    slot_next = slot;
    if (insert_here) begin
      slot_next = new_entry;
    end else if (shift_down) begin
      slot_next = prev_slot;
    end else if (shift_up) begin
      slot_next = next_slot;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot <= '0;
    end else begin
      slot <= slot_next;
    end
  end

endmodule

// File: rtl/pifo_calendar.sv
// pifo_calendar
//   Root-level PIFO calendar: a sorted shift-register array of {rank, addr}
//   entries, smallest wrap-relative rank at the head. Supports insert, pop,
//   and insert+pop in the same cycle.
//   Ports:
//     clk, rstn                : clock, asynchronous active-low reset
//     s_axis_pifo_info_root    : entry to insert, {rank, buffer address}
//     s_axis_insert_en         : insert request
//     s_axis_pop_en            : pop request
//     s_axis_global_pifo       : virtual-time base for rank comparison
//     m_axis_pifo_calendar_top : registered head entry {rank, addr}, 0 if empty
//     m_axis_buffer_addr       : address of the most recently popped entry
//     m_axis_calendar_full     : count == PIFO_CALENDAR_SIZE
//     m_axis_calendar_count    : number of valid entries
//   Rank and address widths come from pifo_calendar_pkg.
module pifo_calendar
  import pifo_calendar_pkg::*;
#(
  parameter int PIFO_CALENDAR_SIZE        = 10,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [PIFO_INFO_WIDTH-1:0]           s_axis_pifo_info_root,
  input  logic                                 s_axis_insert_en,
  input  logic                                 s_axis_pop_en,
  input  logic [PIFO_RANK_WIDTH-1:0]           s_axis_global_pifo,
  output logic [PIFO_INFO_WIDTH-1:0]           m_axis_pifo_calendar_top,
  output logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_buffer_addr,
  output logic                                 m_axis_calendar_full,
  output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] m_axis_calendar_count
);

  localparam int SIZE = PIFO_CALENDAR_SIZE;
  localparam int IW   = PIFO_CALENDAR_INDEX_WIDTH;
  typedef logic [IW-1:0] idx_t;
  localparam idx_t SIZE_C = idx_t'(SIZE);

  entry_t slots      [SIZE];
  entry_t slots_next [SIZE];
  entry_t prev_of    [SIZE];
  entry_t next_of    [SIZE];
  entry_t new_entry;

  logic [SIZE-1:0] gt;
  logic [SIZE-1:0] insert_here;
  logic [SIZE-1:0] shift_down;
  logic [SIZE-1:0] shift_up;

  logic do_pop;
  logic do_ins;
  idx_t ins_idx;
  idx_t ins_idx_pop;
  idx_t count_q;
  idx_t count_next;
  logic full_q;
  logic [PIFO_INFO_WIDTH-1:0] top_q;
  addr_t buf_addr_q;

  assign new_entry = '{valid: 1'b1,
                       rank:  s_axis_pifo_info_root[INFO_RANK_MSB:INFO_RANK_LSB],
                       addr:  s_axis_pifo_info_root[INFO_ADDR_MSB:INFO_ADDR_LSB]};

  // Neighbour wiring; the ends of the array see an empty slot.
  always_comb begin
    prev_of[0]      = '0;
    next_of[SIZE-1] = '0;
    for (int i = 1; i < SIZE; i++) begin
      prev_of[i] = slots[i-1];
    end
    for (int i = 0; i < SIZE - 1; i++) begin
      next_of[i] = slots[i+1];
    end
  end

  // gt[i]: slot i sorts strictly after the incoming entry. Equal keys are
  // not "greater", which places the new entry behind them (FIFO on ties).
  always_comb begin
    gt = '0;
    for (int i = 0; i < SIZE; i++) begin
      gt[i] = slots[i].valid &&
              rank_key_gt(slots[i].rank, new_entry.rank, s_axis_global_pifo);
    end
  end

  // ins_idx is the landing slot for a plain insert. ins_idx_pop is the
  // landing slot when the head leaves in the same cycle: search from slot 1
  // and subtract one because everything ahead of it moves up.
  always_comb begin
    ins_idx     = count_q;
    ins_idx_pop = count_q - idx_t'(1);
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (gt[i]) ins_idx = idx_t'(i);
    end
    for (int i = SIZE - 1; i >= 1; i--) begin
      if (gt[i]) ins_idx_pop = idx_t'(i - 1);
    end
  end

  // A pop on an empty calendar is ignored; an insert is dropped only when
  // the calendar is full and no pop frees a slot in the same cycle.
  always_comb begin
    do_pop = s_axis_pop_en && (count_q != '0);
    do_ins = s_axis_insert_en && (do_pop || (count_q != SIZE_C));
  end

  always_comb begin
    insert_here = '0;
    shift_down  = '0;
    shift_up    = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (do_pop && do_ins) begin
        if (idx_t'(i) < ins_idx_pop) begin
          shift_up[i] = 1'b1;
        end else if (idx_t'(i) == ins_idx_pop) begin
          insert_here[i] = 1'b1;
        end
      end else if (do_pop) begin
        shift_up[i] = 1'b1;
      end else if (do_ins) begin
        if (idx_t'(i) == ins_idx) begin
          insert_here[i] = 1'b1;
        end else if (idx_t'(i) > ins_idx) begin
          shift_down[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_slot
    pifo_calendar_slot u_slot (
      .clk         (clk),
      .rstn        (rstn),
      .prev_slot   (prev_of[g]),
      .next_slot   (next_of[g]),
      .new_entry   (new_entry),
      .insert_here (insert_here[g]),
      .shift_down  (shift_down[g]),
      .shift_up    (shift_up[g]),
      .slot        (slots[g]),
      .slot_next   (slots_next[g])
    );
  end

  always_comb begin
    count_next = count_q;
    if (do_pop && !do_ins) begin
      count_next = count_q - idx_t'(1);
    end else if (do_ins && !do_pop) begin
      count_next = count_q + idx_t'(1);
    end
  end

  // Head register tracks the slot-0 value being written this edge so that
  // it stays aligned with count and full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      top_q      <= '0;
      buf_addr_q <= '0;
    end else begin
      count_q <= count_next;
      full_q  <= (count_next == SIZE_C);
      top_q   <= slots_next[0].valid ? {slots_next[0].rank, slots_next[0].addr} : '0;
      if (do_pop) begin
        buf_addr_q <= slots[0].addr;
      end
    end
  end

  assign m_axis_pifo_calendar_top = top_q;
  assign m_axis_buffer_addr       = buf_addr_q;
  assign m_axis_calendar_full     = full_q;
  assign m_axis_calendar_count    = count_q;

endmodule

// File: tb/tb_pifo_calendar.sv
// tb_pifo_calendar
//   Directed, table-driven bench for pifo_calendar. Each vector drives one
//   cycle of insert/pop/base and lists the expected count, full, popped
//   address and (optionally) head entry after that edge. A hand-written
//   sequence covers filling, overflow and pop+insert at full.
module tb_pifo_calendar;
  import pifo_calendar_pkg::*;

  logic        clk;
  logic        rstn;
  logic [27:0] info;
  logic        insert_en;
  logic        pop_en;
  logic [15:0] base;
  logic [27:0] top;
  logic [11:0] buf_addr;
  logic        full;
  logic [3:0]  count;

  int total_checks;
  int passed_checks;

  typedef struct {
    string       name;
    logic        ins;
    logic        pop;
    logic [15:0] rank;
    logic [11:0] addr;
    logic [15:0] base;
    logic [3:0]  exp_count;
    logic        exp_full;
    logic [11:0] exp_buf;
    logic        chk_top;
    logic [27:0] exp_top;
  } vec_t;

  vec_t vecs[$];

  pifo_calendar dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .s_axis_pifo_info_root    (info),
    .s_axis_insert_en         (insert_en),
    .s_axis_pop_en            (pop_en),
    .s_axis_global_pifo       (base),
    .m_axis_pifo_calendar_top (top),
    .m_axis_buffer_addr       (buf_addr),
    .m_axis_calendar_full     (full),
    .m_axis_calendar_count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic ins, logic pop, logic [15:0] rank,
                              logic [11:0] addr, logic [15:0] b, logic [3:0] cnt,
                              logic fl, logic [11:0] bufa, logic chk, logic [27:0] tp);
    vec_t v;
    v.name = n; v.ins = ins; v.pop = pop; v.rank = rank; v.addr = addr; v.base = b;
    v.exp_count = cnt; v.exp_full = fl; v.exp_buf = bufa; v.chk_top = chk; v.exp_top = tp;
    return v;
  endfunction

  task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  // Drive one cycle of stimulus, then sample #1 after the rising edge.
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    insert_en = v.ins;
    pop_en    = v.pop;
    info      = {v.rank, v.addr};
    base      = v.base;
    @(posedge clk);
    #1;
    insert_en = 1'b0;
    pop_en    = 1'b0;
  endtask

  task automatic checkOutput(vec_t v);
    checkField({v.name, ".count"}, 32'(count), 32'(v.exp_count));
    checkField({v.name, ".full"}, 32'(full), 32'(v.exp_full));
    checkField({v.name, ".buf_addr"}, 32'(buf_addr), 32'(v.exp_buf));
    if (v.chk_top) checkField({v.name, ".top"}, 32'(top), 32'(v.exp_top));
  endtask

  // Expected pop order after the full/pop+insert sequence (ranks 110..190
  // plus the inserted 135).
  logic [11:0] full_pop_order [10];

  initial begin
    vec_t v;
    total_checks  = 0;
    passed_checks = 0;
    insert_en = 1'b0;
    pop_en    = 1'b0;
    info      = '0;
    base      = '0;
    rstn      = 1'b0;

    //            name        ins  pop  rank     addr    base     cnt full buf    chk top
    vecs.push_back(mk("ins30",  1, 0, 16'd30,  12'h003, 16'h0000, 1, 0, 12'h000, 0, 28'h0));
    vecs.push_back(mk("ins10",  1, 0, 16'd10,  12'h001, 16'h0000, 2, 0, 12'h000, 0, 28'h0));
    vecs.push_back(mk("ins20",  1, 0, 16'd20,  12'h002, 16'h0000, 3, 0, 12'h000, 0, 28'h0));
    vecs.push_back(mk("idle1",  0, 0, 16'd0,   12'h000, 16'h0000, 3, 0, 12'h000, 1, {16'd10, 12'h001}));
    vecs.push_back(mk("pop1",   0, 1, 16'd0,   12'h000, 16'h0000, 2, 0, 12'h001, 0, 28'h0));
    vecs.push_back(mk("pop2",   0, 1, 16'd0,   12'h000, 16'h0000, 1, 0, 12'h002, 0, 28'h0));
    vecs.push_back(mk("pop3",   0, 1, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h003, 0, 28'h0));
    vecs.push_back(mk("idle2",  0, 0, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h003, 1, 28'h0));
    vecs.push_back(mk("epop",   0, 1, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h003, 0, 28'h0));
    vecs.push_back(mk("idle3",  0, 0, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h003, 1, 28'h0));
    vecs.push_back(mk("tieA",   1, 0, 16'd5,   12'h00A, 16'h0000, 1, 0, 12'h003, 0, 28'h0));
    vecs.push_back(mk("tieB",   1, 0, 16'd5,   12'h00B, 16'h0000, 2, 0, 12'h003, 0, 28'h0));
    vecs.push_back(mk("tieTop", 0, 0, 16'd0,   12'h000, 16'h0000, 2, 0, 12'h003, 1, {16'd5, 12'h00A}));
    vecs.push_back(mk("tiePopA",0, 1, 16'd0,   12'h000, 16'h0000, 1, 0, 12'h00A, 0, 28'h0));
    vecs.push_back(mk("tiePopB",0, 1, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h00B, 0, 28'h0));
    vecs.push_back(mk("wrap5",  1, 0, 16'h0005,12'h021, 16'hFFF0, 1, 0, 12'h00B, 0, 28'h0));
    vecs.push_back(mk("wrapF8", 1, 0, 16'hFFF8,12'h022, 16'hFFF0, 2, 0, 12'h00B, 0, 28'h0));
    vecs.push_back(mk("wrapTop",0, 0, 16'd0,   12'h000, 16'hFFF0, 2, 0, 12'h00B, 1, {16'hFFF8, 12'h022}));
    vecs.push_back(mk("wrapP1", 0, 1, 16'd0,   12'h000, 16'hFFF0, 1, 0, 12'h022, 0, 28'h0));
    vecs.push_back(mk("wrapP2", 0, 1, 16'd0,   12'h000, 16'hFFF0, 0, 0, 12'h021, 0, 28'h0));
    vecs.push_back(mk("epopIns",1, 1, 16'd7,   12'h030, 16'h0000, 1, 0, 12'h021, 0, 28'h0));
    vecs.push_back(mk("epiTop", 0, 0, 16'd0,   12'h000, 16'h0000, 1, 0, 12'h021, 1, {16'd7, 12'h030}));
    vecs.push_back(mk("epiPop", 0, 1, 16'd0,   12'h000, 16'h0000, 0, 0, 12'h030, 0, 28'h0));

    full_pop_order[0] = 12'h107; full_pop_order[1] = 12'h104;
    full_pop_order[2] = 12'h101; full_pop_order[3] = 12'h1AA;
    full_pop_order[4] = 12'h108; full_pop_order[5] = 12'h105;
    full_pop_order[6] = 12'h102; full_pop_order[7] = 12'h109;
    full_pop_order[8] = 12'h106; full_pop_order[9] = 12'h103;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkField("reset.count", 32'(count), 32'd0);
    checkField("reset.full", 32'(full), 32'd0);
    checkField("reset.top", 32'(top), 32'd0);
    checkField("reset.buf_addr", 32'(buf_addr), 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Fill: ranks 100 + ((i*3)%10)*10, addr 0x100+i, in scrambled order.
    for (int i = 0; i < 10; i++) begin
      v = mk($sformatf("fill%0d", i), 1, 0, 16'(100 + ((i * 3) % 10) * 10),
             12'(12'h100 + i), 16'h0000, 4'(i + 1), (i == 9), 12'h030, 0, 28'h0);
      applyStimulus(v);
      checkOutput(v);
    end

    // Overflow insert of a would-be head must be dropped.
    v = mk("overflow", 1, 0, 16'd50, 12'h1FF, 16'h0000, 10, 1, 12'h030, 0, 28'h0);
    applyStimulus(v);
    checkOutput(v);
    v = mk("fullTop", 0, 0, 16'd0, 12'h000, 16'h0000, 10, 1, 12'h030, 1, {16'd100, 12'h100});
    applyStimulus(v);
    checkOutput(v);

    // Pop+insert while full: head leaves, 135 lands between 130 and 140.
    v = mk("popIns", 1, 1, 16'd135, 12'h1AA, 16'h0000, 10, 1, 12'h100, 0, 28'h0);
    applyStimulus(v);
    checkOutput(v);
    v = mk("popInsTop", 0, 0, 16'd0, 12'h000, 16'h0000, 10, 1, 12'h100, 1, {16'd110, 12'h107});
    applyStimulus(v);
    checkOutput(v);

    for (int i = 0; i < 10; i++) begin
      v = mk($sformatf("drain%0d", i), 0, 1, 16'd0, 12'h000, 16'h0000,
             4'(9 - i), 1'b0, full_pop_order[i], 0, 28'h0);
      applyStimulus(v);
      checkOutput(v);
    end

    v = mk("drainTop", 0, 0, 16'd0, 12'h000, 16'h0000, 0, 0, 12'h103, 1, 28'h0);
    applyStimulus(v);
    checkOutput(v);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
